// File: rtl/sd_block_sequencer.sv
// sd_block_sequencer
//   Drives the spiMaster register bus on behalf of the logging datapath.
//   It runs SD card initialisation and 512-byte block writes from a byte
//   stream. Each command ends with a one-cycle done pulse, and error and
//   err_code qualify that pulse.
//
// Ports
//   clk_peri, reset        clock, synchronous active-high reset
//   cmd_init, cmd_write    command requests (accepted while cmd_ready=1)
//   cmd_block[31:0]        block number for cmd_write
//   cmd_ready              sequencer idle
//   s_data/s_valid/s_ready payload byte stream
//   done/error/err_code    completion pulse and result (0 ok, 1 card, 2 timeout)
//   spi_*                  spiMaster register bus (addr, wdata, rdata, strobe, we)
//
// state      | meaning
// -----------+------------------------------------------------------
// S_IDLE     | waiting for a command, cmd_ready=1
// S_FLUSH    | write 1 to TX FIFO control (flush)
// S_FILL     | accept 512 payload bytes, write each to TX FIFO data
// S_ADDR     | write byte address LSB first to SD_ADDR0..3
// S_TYPE     | write transaction type (1 init, 3 block write)
// S_START    | write 1 to transaction control
// S_POLL_WAIT| gap timer before the next status read, then issue it
// S_POLL_CHK | evaluate status busy bit, count polls, detect timeout
// S_ERR_RD   | read the error register
// S_ERR_CHK  | evaluate the error field and finish
module sd_block_sequencer #(
    parameter logic [5:0]  REG_TRANS_TYPE   = 6'h02,
    parameter logic [5:0]  REG_TRANS_CTRL   = 6'h03,
    parameter logic [5:0]  REG_TRANS_STS    = 6'h04,
    parameter logic [5:0]  REG_TRANS_ERR    = 6'h05,
    parameter logic [5:0]  REG_SD_ADDR0     = 6'h07,
    parameter logic [5:0]  REG_TX_FIFO_DATA = 6'h20,
    parameter logic [5:0]  REG_TX_FIFO_CTRL = 6'h24,
    parameter int unsigned POLL_GAP         = 16,
    parameter int unsigned TIMEOUT_POLLS    = 65535
) (
    input  logic        clk_peri,
    input  logic        reset,
    input  logic        cmd_init,
    input  logic        cmd_write,
    input  logic [31:0] cmd_block,
    output logic        cmd_ready,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [5:0]  spi_addr,
    output logic [7:0]  spi_wdata,
    input  logic [7:0]  spi_rdata,
    output logic        spi_strobe,
    output logic        spi_we
);

    typedef enum logic [3:0] {
        S_IDLE, S_FLUSH, S_FILL, S_ADDR, S_TYPE,
        S_START, S_POLL_WAIT, S_POLL_CHK, S_ERR_RD, S_ERR_CHK
    } state_t;

    localparam logic [15:0] GAP_LOAD     = 16'(POLL_GAP - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_POLLS - 1);

    state_t      state, state_nxt;
    logic        gap_q;
    logic [7:0]  byte_q;
    logic        byte_pend;
    logic [9:0]  byte_cnt;
    logic [1:0]  addr_idx;
    logic [15:0] timer;
    logic [15:0] poll_cnt;
    logic [31:0] blk_q;
    logic        is_write;
    logic        done_q, error_q;
    logic [1:0]  err_code_q;
    logic [31:0] sd_addr;
    logic [1:0]  err_field;

    logic accept_cmd, accept_byte, byte_wr, addr_wr, start_wr, poll_busy;
    logic finish, fin_err;
    logic [1:0] fin_code;

    // Byte address = block * 512; the shift drops cmd_block[31:23].
    assign sd_addr   = blk_q << 9;
    assign err_field = is_write ? spi_rdata[5:4] : spi_rdata[1:0];

    logic unused_rdata;
    assign unused_rdata = ^{spi_rdata[7:6], spi_rdata[3:2]};

    assign cmd_ready = (state == S_IDLE);
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;

    always_ff @(posedge clk_peri) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // gap_q marks the cycle right after a strobe; no strobe may issue then.
    always_comb begin
        state_nxt   = state;
        spi_strobe  = 1'b0;
        spi_we      = 1'b0;
        spi_addr    = '0;
        spi_wdata   = '0;
        s_ready     = 1'b0;
        accept_cmd  = 1'b0;
        accept_byte = 1'b0;
        byte_wr     = 1'b0;
        addr_wr     = 1'b0;
        start_wr    = 1'b0;
        poll_busy   = 1'b0;
        finish      = 1'b0;
        fin_err     = 1'b0;
        fin_code    = 2'd0;
        case (state)
            S_IDLE: begin
                if (cmd_init) begin
                    accept_cmd = 1'b1;
                    state_nxt  = S_TYPE;
                end else if (cmd_write) begin
                    accept_cmd = 1'b1;
                    state_nxt  = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!gap_q) begin
                    spi_strobe = 1'b1;
                    spi_we     = 1'b1;
                    spi_addr   = REG_TX_FIFO_CTRL;
                    spi_wdata  = 8'h01;
                    state_nxt  = S_FILL;
                end
            end
            S_FILL: begin
                if (byte_pend) begin
                    spi_strobe = 1'b1;
                    spi_we     = 1'b1;
                    spi_addr   = REG_TX_FIFO_DATA;
                    spi_wdata  = byte_q;
                    byte_wr    = 1'b1;
                    if (byte_cnt == 10'd511) state_nxt = S_ADDR;
                end else begin
                    s_ready     = 1'b1;
                    accept_byte = s_valid;
                end
            end
            S_ADDR: begin
                if (!gap_q) begin
                    spi_strobe = 1'b1;
                    spi_we     = 1'b1;
                    spi_addr   = REG_SD_ADDR0 + 6'(addr_idx);
                    spi_wdata  = sd_addr[{addr_idx, 3'b000} +: 8];
                    addr_wr    = 1'b1;
                    if (addr_idx == 2'd3) state_nxt = S_TYPE;
                end
            end
            S_TYPE: begin
                if (!gap_q) begin
                    spi_strobe = 1'b1;
                    spi_we     = 1'b1;
                    spi_addr   = REG_TRANS_TYPE;
                    spi_wdata  = is_write ? 8'h03 : 8'h01;
                    state_nxt  = S_START;
                end
            end
            S_START: begin
                if (!gap_q) begin
                    spi_strobe = 1'b1;
                    spi_we     = 1'b1;
                    spi_addr   = REG_TRANS_CTRL;
                    spi_wdata  = 8'h01;
                    start_wr   = 1'b1;
                    state_nxt  = S_POLL_WAIT;
                end
            end
            S_POLL_WAIT: begin
                if (timer == 16'd0 && !gap_q) begin
                    spi_strobe = 1'b1;
                    spi_addr   = REG_TRANS_STS;
                    state_nxt  = S_POLL_CHK;
                end
            end
            S_POLL_CHK: begin
                if (!spi_rdata[0]) begin
                    state_nxt = S_ERR_RD;
                end else if (poll_cnt == TIMEOUT_LAST) begin
                    finish    = 1'b1;
                    fin_err   = 1'b1;
                    fin_code  = 2'd2;
                    state_nxt = S_IDLE;
                end else begin
                    poll_busy = 1'b1;
                    state_nxt = S_POLL_WAIT;
                end
            end
            S_ERR_RD: begin
                if (!gap_q) begin
                    spi_strobe = 1'b1;
                    spi_addr   = REG_TRANS_ERR;
                    state_nxt  = S_ERR_CHK;
                end
            end
            S_ERR_CHK: begin
                finish    = 1'b1;
                state_nxt = S_IDLE;
                if (err_field != 2'd0) begin
                    fin_err  = 1'b1;
                    fin_code = 2'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_peri) begin
        if (reset) begin
            gap_q      <= 1'b0;
            byte_q     <= '0;
            byte_pend  <= 1'b0;
            byte_cnt   <= '0;
            addr_idx   <= '0;
            timer      <= '0;
            poll_cnt   <= '0;
            blk_q      <= '0;
            is_write   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= '0;
        end else begin
            gap_q  <= spi_strobe;
            done_q <= finish;
            if (accept_cmd) begin
                blk_q      <= cmd_block;
                is_write   <= !cmd_init;
                error_q    <= 1'b0;
                err_code_q <= 2'd0;
                byte_cnt   <= '0;
                addr_idx   <= '0;
                byte_pend  <= 1'b0;
            end
            if (finish) begin
                error_q    <= fin_err;
                err_code_q <= fin_code;
            end
            if (accept_byte) begin
                byte_q    <= s_data;
                byte_pend <= 1'b1;
            end
            if (byte_wr) begin
                byte_pend <= 1'b0;
                byte_cnt  <= byte_cnt + 10'd1;
            end
            if (addr_wr) addr_idx <= addr_idx + 2'd1;
            if (start_wr) begin
                timer    <= GAP_LOAD;
                poll_cnt <= '0;
            end else if (poll_busy) begin
                timer    <= GAP_LOAD;
                poll_cnt <= poll_cnt + 16'd1;
            end else if (state == S_POLL_WAIT && timer != 16'd0) begin
                timer <= timer - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sd_block_sequencer.sv
// Testbench for sd_block_sequencer: a behavioural spiMaster responder logs
// every bus cycle, and the expected bus traffic and results for each
// command are built from the command parameters and the payload stream.
module tb_sd_block_sequencer;
    localparam int POLL_GAP      = 16;
    localparam int TIMEOUT_POLLS = 4;

    logic        clk_peri = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_init = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_block = '0;
    logic        cmd_ready;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        done, error;
    logic [1:0]  err_code;
    logic [5:0]  spi_addr;
    logic [7:0]  spi_wdata;
    logic [7:0]  spi_rdata = '0;
    logic        spi_strobe, spi_we;

    always #5 clk_peri = ~clk_peri;

    sd_block_sequencer #(.POLL_GAP(POLL_GAP), .TIMEOUT_POLLS(TIMEOUT_POLLS)) dut (
        .clk_peri(clk_peri), .reset(reset),
        .cmd_init(cmd_init), .cmd_write(cmd_write), .cmd_block(cmd_block),
        .cmd_ready(cmd_ready),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .done(done), .error(error), .err_code(err_code),
        .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
        .spi_strobe(spi_strobe), .spi_we(spi_we)
    );

    typedef struct packed {
        logic       we;
        logic [5:0] addr;
        logic [7:0] data;
    } txn_t;

    txn_t       log_q[$];
    int         log_cyc[$];
    txn_t       exp_q[$];
    logic [7:0] stream [512];

    int         n_tests = 0, n_fail = 0;
    int         cyc = 0, last_strobe = -10;
    int         busy_left = 0;
    bit         busy_forever = 1'b0;
    logic [7:0] err_val = '0;
    int         done_seen = 0;

    // spiMaster responder: logs bus cycles, serves status/error reads.
    always @(negedge clk_peri) begin
        cyc++;
        if (done === 1'b1) done_seen++;
        if (spi_strobe === 1'b1) begin
            n_tests++;
            assert (cyc - last_strobe >= 2) else begin
                n_fail++;
                $error("FAIL strobe_spacing: observed gap %0d, expected >= 2", cyc - last_strobe);
            end
            last_strobe = cyc;
            log_q.push_back(txn_t'({spi_we, spi_addr, spi_wdata}));
            log_cyc.push_back(cyc);
            if (!spi_we) begin
                if (spi_addr == 6'h04) begin
                    spi_rdata = {7'b0, (busy_forever || busy_left > 0)};
                    if (busy_left > 0) busy_left--;
                end else if (spi_addr == 6'h05) begin
                    spi_rdata = err_val;
                end else begin
                    spi_rdata = 8'h5A;
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        assert (act === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, expv);
        end
    endtask

    // Reference traffic builders.
    task automatic exp_tail(input int busy_polls, input bit timeout);
        exp_q.push_back(txn_t'({1'b1, 6'h03, 8'h01}));
        if (timeout) begin
            repeat (TIMEOUT_POLLS) exp_q.push_back(txn_t'({1'b0, 6'h04, 8'h00}));
        end else begin
            repeat (busy_polls + 1) exp_q.push_back(txn_t'({1'b0, 6'h04, 8'h00}));
            exp_q.push_back(txn_t'({1'b0, 6'h05, 8'h00}));
        end
    endtask

    task automatic exp_init(input int busy_polls, input bit timeout);
        exp_q.delete();
        exp_q.push_back(txn_t'({1'b1, 6'h02, 8'h01}));
        exp_tail(busy_polls, timeout);
    endtask

    task automatic exp_write(input logic [31:0] blk, input int busy_polls);
        logic [31:0] byte_addr;
        byte_addr = blk * 32'd512;
        exp_q.delete();
        exp_q.push_back(txn_t'({1'b1, 6'h24, 8'h01}));
        for (int i = 0; i < 512; i++) exp_q.push_back(txn_t'({1'b1, 6'h20, stream[i]}));
        for (int k = 0; k < 4; k++)
            exp_q.push_back(txn_t'({1'b1, 6'(7 + k), byte_addr[8*k +: 8]}));
        exp_q.push_back(txn_t'({1'b1, 6'h02, 8'h03}));
        exp_tail(busy_polls, 1'b0);
    endtask

    task automatic check_log(input string tag);
        txn_t a, e;
        check({tag, "_txn_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            a = log_q[i];
            e = exp_q[i];
            if (!e.we) a.data = e.data;
            check($sformatf("%s_txn%0d", tag, i), 32'(a), 32'(e));
        end
    endtask

    task automatic issue(input logic ini, input logic wr, input logic [31:0] blk, input string tag);
        @(negedge clk_peri);
        log_q.delete();
        log_cyc.delete();
        done_seen = 0;
        check({tag, "_ready_before"}, 32'(cmd_ready), 32'd1);
        cmd_init = ini;
        cmd_write = wr;
        cmd_block = blk;
        @(negedge clk_peri);
        cmd_init = 1'b0;
        cmd_write = 1'b0;
        cmd_block = $urandom;
        check({tag, "_ready_dropped"}, 32'(cmd_ready), 32'd0);
        check({tag, "_error_cleared"}, {29'd0, error, err_code}, 32'd0);
    endtask

    task automatic feed(input int first, input int count, input int max_gap);
        int w;
        for (int i = first; i < first + count; i++) begin
            @(negedge clk_peri);
            s_valid = 1'b0;
            repeat ($urandom_range(0, max_gap)) @(negedge clk_peri);
            s_data = stream[i];
            s_valid = 1'b1;
            w = 0;
            while (s_ready !== 1'b1 && w < 200) begin
                @(negedge clk_peri);
                w++;
            end
            if (w >= 200) begin
                check($sformatf("s_ready_timeout_byte%0d", i), 32'(w), 32'd0);
                break;
            end
        end
        @(negedge clk_peri);
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag,
                             input logic exp_err, input logic [1:0] exp_code);
        int k = 0;
        while (k < budget && done !== 1'b1) begin
            @(negedge clk_peri);
            k++;
        end
        check({tag, "_done_in_time"}, 32'(k < budget), 32'd1);
        check({tag, "_result"}, {29'd0, error, err_code}, {29'd0, exp_err, exp_code});
        check({tag, "_ready_with_done"}, 32'(cmd_ready), 32'd1);
        @(negedge clk_peri);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_result_held"}, {29'd0, error, err_code}, {29'd0, exp_err, exp_code});
        check({tag, "_done_count"}, 32'(done_seen), 32'd1);
    endtask

    initial begin
        logic [31:0] blk;
        int          bp;

        // Reset and idle
        repeat (3) @(negedge clk_peri);
        check("reset_outputs",
              {16'd0, cmd_ready, s_ready, done, error, err_code, spi_strobe, spi_we, spi_addr},
              {16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 6'd0});
        check("reset_wdata", 32'(spi_wdata), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_peri);
            check($sformatf("idle_c%0d", i), {29'd0, cmd_ready, s_ready, spi_strobe}, 32'b100);
        end

        // Init: busy 3 polls, error reg 0; a cmd_write during the command is ignored
        busy_left = 3;
        err_val = 8'h00;
        exp_init(3, 1'b0);
        issue(1'b1, 1'b0, 32'h0, "init");
        repeat (25) @(negedge clk_peri);
        cmd_write = 1'b1;
        repeat (3) @(negedge clk_peri);
        cmd_write = 1'b0;
        wait_done(400, "init", 1'b0, 2'd0);
        check_log("init");
        if (log_q.size() >= 3)
            check("init_first_poll_gap", 32'(log_cyc[2] - log_cyc[1]), 32'(POLL_GAP));
        for (int i = 3; i < log_q.size() && i < 6; i++)
            check($sformatf("init_poll_spacing%0d", i), 32'(log_cyc[i] - log_cyc[i-1] >= POLL_GAP), 32'd1);

        // Block 5, stream 0..255 twice, stall mid-FILL
        for (int i = 0; i < 512; i++) stream[i] = 8'(i);
        bp = $urandom_range(0, 2);
        busy_left = bp;
        err_val = 8'h00;
        exp_write(32'h5, bp);
        issue(1'b0, 1'b1, 32'h0000_0005, "wr5");
        feed(0, 300, 3);
        repeat (100) @(negedge clk_peri);
        check("wr5_stall_writes", 32'(log_q.size()), 32'd301);
        check("wr5_stall_no_done", 32'(done_seen), 32'd0);
        feed(300, 212, 3);
        wait_done(400, "wr5", 1'b0, 2'd0);
        check_log("wr5");

        // Random block (high bits set), random stream, card error in write field
        for (int i = 0; i < 512; i++) stream[i] = 8'($urandom);
        blk = $urandom | 32'hFF80_0000;
        bp = $urandom_range(0, 2);
        busy_left = bp;
        err_val = 8'h10;
        exp_write(blk, bp);
        issue(1'b0, 1'b1, blk, "wrerr");
        feed(0, 512, 2);
        wait_done(400, "wrerr", 1'b1, 2'd1);
        check_log("wrerr");

        // Init ignores the write error field
        busy_left = 0;
        err_val = 8'h30;
        exp_init(0, 1'b0);
        issue(1'b1, 1'b0, 32'h0, "init30");
        wait_done(400, "init30", 1'b0, 2'd0);
        check_log("init30");

        // Init reports its own field
        busy_left = 1;
        err_val = 8'h02;
        exp_init(1, 1'b0);
        issue(1'b1, 1'b0, 32'h0, "init02");
        wait_done(400, "init02", 1'b1, 2'd1);
        check_log("init02");

        // Timeout: status busy forever
        busy_forever = 1'b1;
        err_val = 8'h00;
        exp_init(0, 1'b1);
        issue(1'b1, 1'b0, 32'h0, "tmo");
        wait_done(400, "tmo", 1'b1, 2'd2);
        check_log("tmo");
        repeat (10) @(negedge clk_peri);
        check("tmo_result_holds", {29'd0, error, err_code}, {29'd0, 1'b1, 2'd2});
        busy_forever = 1'b0;

        // Reset at payload byte 100
        for (int i = 0; i < 512; i++) stream[i] = 8'($urandom);
        issue(1'b0, 1'b1, 32'h1234, "rst");
        feed(0, 99, 1);
        @(negedge clk_peri);
        s_data = stream[99];
        s_valid = 1'b1;
        bp = 0;
        while (s_ready !== 1'b1 && bp < 50) begin
            @(negedge clk_peri);
            bp++;
        end
        @(posedge clk_peri);
        #1;
        reset = 1'b1;
        @(posedge clk_peri);
        #1;
        log_q.delete();
        log_cyc.delete();
        done_seen = 0;
        reset = 1'b0;
        repeat (30) @(negedge clk_peri);
        check("rst_no_strobes", 32'(log_q.size()), 32'd0);
        check("rst_no_done", 32'(done_seen), 32'd0);
        check("rst_idle", {30'd0, cmd_ready, s_ready}, 32'b10);
        s_valid = 1'b0;

        // Recovery; cmd_init wins over a simultaneous cmd_write
        busy_left = 1;
        err_val = 8'h00;
        exp_init(1, 1'b0);
        issue(1'b1, 1'b1, 32'hFFFF_FFFF, "recov");
        wait_done(400, "recov", 1'b0, 2'd0);
        check_log("recov");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
